// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl: two-pass write/read-back BIST for a 64x8 memory, reports first failing location
module mem_bist_ctrl #(
  parameter int                ADDR_W       = 6,
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] SEED         = 8'hA5,
  parameter bit                STOP_ON_FAIL = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [7:0]        err_cnt
);
  typedef enum logic [2:0] {IDLE, W0, R0, D0, W1, R1, D1, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] a_q, a_d, raddr_q, raddr_d, fa_q, fa_d;
  logic [DATA_W-1:0] wd_q, wd_d, rexp_q, rexp_d, fe_q, fe_d, fg_q, fg_d;
  logic [7:0] err_q, err_d;
  logic wr_q, wr_d, rd_q, rd_d, rv_q, rv_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d, mm;

  function automatic logic [DATA_W-1:0] pat(input state_t s, input logic [ADDR_W-1:0] a);
    pat = (s inside {W1, R1}) ? ~(DATA_W'(a) ^ SEED) : DATA_W'(a) ^ SEED;
  endfunction

  always_comb begin
    mm = rv_q && (state_q inside {R0, D0, R1, D1}) && (mem_rdata != rexp_q);
    state_d = state_q;
    a_d = a_q;
    err_d = err_q;
    fa_d = fa_q;
    fe_d = fe_q;
    fg_d = fg_q;
    rv_d = state_q inside {R0, R1};
    rexp_d = pat(state_q, a_q);
    raddr_d = a_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = W0;
        a_d = '0;
        err_d = '0;
        fa_d = '0;
        fe_d = '0;
        fg_d = '0;
      end
      D0: state_d = W1;
      D1: state_d = DONE;
      default: begin
        a_d = a_q + 1'b1;
        if (&a_q) state_d = state_t'(state_q + 3'd1);
      end
    endcase
    if (mm) begin
      err_d = (&err_q) ? err_q : err_q + 8'd1;
      if (err_q == '0) begin
        fa_d = raddr_q;
        fe_d = rexp_q;
        fg_d = mem_rdata;
      end
      if (STOP_ON_FAIL) begin
        state_d = DONE;
        a_d = '0;
      end
    end
    if (abort) begin
      state_d = IDLE;
      a_d = '0;
      err_d = err_q;
      fa_d = fa_q;
      fe_d = fe_q;
      fg_d = fg_q;
    end
    wr_d = state_d inside {W0, W1};
    rd_d = state_d inside {R0, R1};
    wd_d = wr_d ? pat(state_d, a_d) : '0;
    busy_d = !(state_d inside {IDLE, DONE});
    done_d = state_d == DONE;
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      a_q <= '0;
      raddr_q <= '0;
      fa_q <= '0;
      wd_q <= '0;
      rexp_q <= '0;
      fe_q <= '0;
      fg_q <= '0;
      err_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      rv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      raddr_q <= raddr_d;
      fa_q <= fa_d;
      wd_q <= wd_d;
      rexp_q <= rexp_d;
      fe_q <= fe_d;
      fg_q <= fg_d;
      err_q <= err_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      rv_q <= rv_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign mem_addr = a_q;
  assign mem_wdata = wd_q;
  assign mem_wr_en = wr_q;
  assign mem_rd_en = rd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign fail_addr = fa_q;
  assign fail_exp = fe_q;
  assign fail_got = fg_q;
  assign err_cnt = err_q;
endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb_mem_bist_ctrl: random fault-injection bench for mem_bist_ctrl (stop and continue variants)
module tb_mem_bist_ctrl;
  localparam logic [7:0] SEED = 8'hA5;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0, mon = 1'b0;
  logic [5:0] addr[2], fa[2];
  logic [7:0] wdata[2], rdata[2], fe[2], fg[2], ec[2];
  logic wr[2], rd[2], busy[2], done[2], pass[2], donep[2];
  logic [7:0] mem[2][64];
  logic [7:0] fm[64], fv[64];
  int checks = 0, failures = 0, j = 0, dj[2], dfirst[2], ea;
  logic [7:0] eerr[2], efe, efg, ewd, wd5, wd134;
  logic [5:0] efa;
  logic epass, act, ewr, erd;

  always #5 clk = ~clk;

  mem_bist_ctrl #(.STOP_ON_FAIL(1)) u_stop (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start(start), .abort(abort),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wr_en(wr[0]), .mem_rd_en(rd[0]),
    .mem_rdata(rdata[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_addr(fa[0]), .fail_exp(fe[0]), .fail_got(fg[0]), .err_cnt(ec[0]));

  mem_bist_ctrl #(.STOP_ON_FAIL(0)) u_cont (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start(start), .abort(abort),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wr_en(wr[1]), .mem_rd_en(rd[1]),
    .mem_rdata(rdata[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_addr(fa[1]), .fail_exp(fe[1]), .fail_got(fg[1]), .err_cnt(ec[1]));

  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (wr[i]) mem[i][addr[i]] <= (wdata[i] & ~fm[addr[i]]) | (fv[addr[i]] & fm[addr[i]]);
      if (rd[i]) rdata[i] <= mem[i][addr[i]];
    end

  task automatic chk(input string n, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] j=%0d got=%0h exp=%0h", n, i, j, got, exp);
    end
  endtask

  task automatic build_model();
    int cnt = 0, rj = 0;
    bit first = 0;
    logic [7:0] e, g;
    efa = '0; efe = '0; efg = '0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 64; a++) begin
        e = p ? ~(8'(a) ^ SEED) : 8'(a) ^ SEED;
        g = (e & ~fm[a]) | (fv[a] & fm[a]);
        if (g != e) begin
          cnt++;
          if (!first) begin
            first = 1; efa = 6'(a); efe = e; efg = g; rj = p ? 193 + a : 64 + a;
          end
        end
      end
    dj[0] = first ? rj + 2 : 258;
    dj[1] = 258;
    eerr[0] = first ? 8'd1 : 8'd0;
    eerr[1] = cnt > 255 ? 8'd255 : 8'(cnt);
    epass = !first;
  endtask

  always @(negedge clk) begin
    if (!mon) begin
      j = 0;
      donep = '{1'b0, 1'b0};
      dfirst = '{-1, -1};
    end else begin
      for (int i = 0; i < 2; i++) begin
        act = j < dj[i];
        ewr = act && (j < 64 || (j >= 129 && j < 193));
        erd = act && ((j >= 64 && j < 128) || (j >= 193 && j < 257));
        ea = j < 64 ? j : j < 128 ? j - 64 : j < 193 ? j - 129 : j - 193;
        ewd = j < 64 ? 8'(ea) ^ SEED : ~(8'(ea) ^ SEED);
        chk("excl", i, wr[i] & rd[i], 0);
        chk("wr_en", i, wr[i], ewr);
        chk("rd_en", i, rd[i], erd);
        chk("busy", i, busy[i], act);
        chk("done", i, done[i], !act);
        if (ewr || erd) chk("addr", i, addr[i], ea);
        if (ewr) chk("wdata", i, wdata[i], ewd);
        if (!act) begin
          chk("pass", i, pass[i], epass);
          chk("err_cnt", i, ec[i], eerr[i]);
          chk("fail_addr", i, fa[i], efa);
          chk("fail_exp", i, fe[i], efe);
          chk("fail_got", i, fg[i], efg);
        end
        if (done[i] && !donep[i]) dfirst[i] = j;
        donep[i] = done[i];
      end
      if (j == 5) wd5 = wdata[0];
      if (j == 134) wd134 = wdata[0];
      j++;
    end
  end

  task automatic run(input bit poke);
    build_model();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    mon = 1'b1;
    if (poke) begin
      repeat (30) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (240) @(negedge clk);
    end else repeat (271) @(negedge clk);
    #1 mon = 1'b0;
    for (int i = 0; i < 2; i++) chk("done_at", i, dfirst[i], dj[i]);
  endtask

  task automatic rst_chk();
    for (int i = 0; i < 2; i++) begin
      chk("rst_en", i, {wr[i], rd[i]}, 0);
      chk("rst_flags", i, {busy[i], done[i], pass[i]}, 0);
      chk("rst_addr", i, addr[i], 0);
      chk("rst_wdata", i, wdata[i], 0);
      chk("rst_fail", i, {fa[i], fe[i], fg[i]}, 0);
      chk("rst_err", i, ec[i], 0);
    end
  endtask

  task automatic clear_faults();
    for (int a = 0; a < 64; a++) begin
      fm[a] = '0;
      fv[a] = '0;
    end
  endtask

  task automatic go();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    clear_faults();
    #2 rst_n = 1'b0;
    #1 rst_chk();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(1);
    chk("w0_a5", 0, wd5, 8'hA0);
    chk("w1_a5", 0, wd134, 8'h5F);
    chk("lat", 0, dfirst[0], 258);
    chk("pass1", 0, pass[0], 1);
    fm[42] = 8'h01;
    run(0);
    chk("s_faddr", 0, fa[0], 6'h2A);
    chk("s_fexp", 0, fe[0], 8'h8F);
    chk("s_fgot", 0, fg[0], 8'h8E);
    chk("s_err", 0, ec[0], 1);
    chk("s_pass", 0, pass[0], 0);
    chk("s_done_at", 0, dfirst[0], 108);
    chk("c_err", 1, ec[1], 1);
    chk("c_fgot", 1, fg[1], 8'h8E);
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("ab_done", 0, {done[0], pass[0], busy[0]}, 0);
    chk("ab_err_kept", 0, ec[0], 1);
    chk("ab_fa_kept", 0, fa[0], 6'h2A);
    for (int r = 0; r < 6; r++) begin
      clear_faults();
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        int a;
        a = $urandom_range(0, 63);
        fm[a] = 8'($urandom);
        fv[a] = 8'($urandom);
      end
      run(r[0]);
    end
    clear_faults();
    go();
    repeat (146) @(negedge clk);
    chk("ab_w1_addr", 0, addr[0], 6'h10);
    chk("ab_w1_wr", 0, wr[0], 1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    for (int i = 0; i < 2; i++) chk("ab_idle", i, {wr[i], rd[i], done[i], busy[i]}, 0);
    @(negedge clk);
    chk("ab_stay", 0, {wr[0], rd[0], busy[0]}, 0);
    run(0);
    chk("ab_rerun", 0, pass[0], 1);
    go();
    repeat (81) @(negedge clk);
    chk("mid_r0_rd", 0, rd[0], 1);
    #2 rst_n = 1'b0;
    #1 rst_chk();
    @(negedge clk) rst_n = 1'b1;
    run(0);
    chk("rst_rerun", 1, pass[1], 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
